// File: rtl/coder_stream_demux.sv
// Splits the idx-tagged coder byte stream into per-lane FIFOs and tracks global end-of-stream.
// Optional DEMUX_STATS_EN adds saturating stat_bytes / stat_drops counters.
module coder_stream_demux #(
  parameter int LANES = 8,
  parameter int DEPTH = 16
) (
  input  logic                 coder_clk,
  input  logic                 coder_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_bits_idx,
  input  logic [7:0]           in_bits_byte,
  input  logic                 in_bits_last,
  output logic [LANES-1:0]     out_valid,
  input  logic [LANES-1:0]     out_ready,
  output logic [8*LANES-1:0]   out_bits_byte,
  output logic [LANES-1:0]     out_bits_last,
  output logic                 stream_done
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]          stat_bytes,
  output logic [15:0]          stat_drops
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    LANES_IDX = 8'(LANES);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;

  logic             idx_legal;
  logic             sel_full;
  logic             accept;
  logic             all_empty_nxt;
  logic [LANES-1:0] lane_sel;
  logic [LANES-1:0] full;
  logic [LANES-1:0] wr_en;
  logic [LANES-1:0] rd_en;
  logic [LANES-1:0] empty_nxt;

  // Handshake: a beat moves on in_valid & in_ready; each lane pops on out_valid & out_ready.
  assign idx_legal = in_bits_idx < LANES_IDX;

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sel[i] = (in_bits_idx == 8'(i));
    end
  end

  assign sel_full      = |(full & lane_sel);
  assign in_ready      = ~coder_rst & (state == RUN) & (~idx_legal | ~sel_full);
  assign accept        = in_valid & in_ready;
  assign wr_en         = {LANES{accept & idx_legal}} & lane_sel;
  assign all_empty_nxt = &empty_nxt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [8:0]    head;

    assign full[g]      = (cnt == FULL_CNT);
    assign rd_en[g]     = out_ready[g] & (cnt != '0);
    assign rd_ptr_nxt   = rd_ptr + PW'(rd_en[g]);
    assign empty_nxt[g] = (cnt_nxt == '0);

    always_comb begin
      cnt_nxt = cnt;
      case ({wr_en[g], rd_en[g]})
        2'b10:   cnt_nxt = cnt + CW'(1);
        2'b01:   cnt_nxt = cnt - CW'(1);
        default: cnt_nxt = cnt;
      endcase
    end

    always_ff @(posedge coder_clk) begin
      if (wr_en[g]) begin
        mem[wr_ptr] <= {in_bits_last, in_bits_byte};
      end
    end

    // head is a registered copy of the entry at rd_ptr; a write landing on the
    // next head slot (empty lane, or last entry being popped) is forwarded into it.
    always_ff @(posedge coder_clk) begin
      if (coder_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        head   <= '0;
      end else begin
        if (wr_en[g]) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        rd_ptr <= rd_ptr_nxt;
        cnt    <= cnt_nxt;
        if (wr_en[g] && (wr_ptr == rd_ptr_nxt)) begin
          head <= {in_bits_last, in_bits_byte};
        end else if (rd_en[g] && (cnt > CW'(1))) begin
          head <= mem[rd_ptr_nxt];
        end
      end
    end

    assign out_valid[g]             = (cnt != '0);
    assign out_bits_byte[8*g +: 8]  = head[7:0];
    assign out_bits_last[g]         = head[8];
  end

  // stream_done is raised for the first cycle in DRAIN where every lane is empty,
  // and that same cycle returns the machine to RUN.
  always_ff @(posedge coder_clk) begin
    if (coder_rst) begin
      state       <= RUN;
      stream_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          stream_done <= 1'b0;
          if (accept && in_bits_last) begin
            state       <= DRAIN;
            stream_done <= all_empty_nxt;
          end
        end
        DRAIN: begin
          if (stream_done) begin
            state       <= RUN;
            stream_done <= 1'b0;
          end else begin
            stream_done <= all_empty_nxt;
          end
        end
        default: begin
          state       <= RUN;
          stream_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge coder_clk) begin
    if (coder_rst) begin
      stat_bytes <= '0;
      stat_drops <= '0;
    end else begin
      if (accept && idx_legal && !(&stat_bytes)) begin
        stat_bytes <= stat_bytes + 32'd1;
      end
      if (accept && !idx_legal && !(&stat_drops)) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_coder_stream_demux.sv
// Self-checking bench for coder_stream_demux: directed scenarios with literal
// expectations plus a randomized run against a per-lane queue model.
module tb_coder_stream_demux;
  localparam int LANES = 8;
  localparam int DEPTH = 16;

  logic                 coder_clk = 1'b0;
  logic                 coder_rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_bits_idx = 8'd0;
  logic [7:0]           in_bits_byte = 8'd0;
  logic                 in_bits_last = 1'b0;
  logic [LANES-1:0]     out_valid;
  logic [LANES-1:0]     out_ready = '0;
  logic [8*LANES-1:0]   out_bits_byte;
  logic [LANES-1:0]     out_bits_last;
  logic                 stream_done;
`ifdef DEMUX_STATS_EN
  logic [31:0]          stat_bytes;
  logic [15:0]          stat_drops;
`endif

  coder_stream_demux #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .coder_clk     (coder_clk),
    .coder_rst     (coder_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_bits_idx   (in_bits_idx),
    .in_bits_byte  (in_bits_byte),
    .in_bits_last  (in_bits_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bits_byte (out_bits_byte),
    .out_bits_last (out_bits_last),
    .stream_done   (stream_done)
`ifdef DEMUX_STATS_EN
    ,
    .stat_bytes    (stat_bytes),
    .stat_drops    (stat_drops)
`endif
  );

  // clock / reset
  always #5 coder_clk = ~coder_clk;

  // reference model: one queue of {last, byte} per lane plus a drain flag
  logic [8:0] exp_q [LANES][$];
  logic       draining = 1'b0;
  int         m_bytes = 0;
  int         m_drops = 0;
  logic       check_en = 1'b0;
  logic       rdy_seen = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic all_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < LANES; i++) if (exp_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic logic exp_ready();
    logic [2:0] li;
    li = in_bits_idx[2:0];
    if (coder_rst || draining) return 1'b0;
    if (in_bits_idx >= 8'(LANES)) return 1'b1;
    return exp_q[li].size() < DEPTH;
  endfunction

  function automatic logic exp_done();
    return draining && all_empty();
  endfunction

  // model update at each active edge, from the pre-edge view
  initial forever begin
    @(posedge coder_clk);
    if (coder_rst) begin
      for (int i = 0; i < LANES; i++) exp_q[i].delete();
      draining = 1'b0;
      m_bytes  = 0;
      m_drops  = 0;
    end else begin
      logic acc;
      logic done_now;
      acc      = in_valid && exp_ready();
      done_now = exp_done();
      for (int i = 0; i < LANES; i++) begin
        if (out_ready[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
      end
      if (acc) begin
        if (in_bits_idx < 8'(LANES)) begin
          exp_q[in_bits_idx[2:0]].push_back({in_bits_last, in_bits_byte});
          if (m_bytes != 32'hFFFF_FFFF) m_bytes++;
        end else if (m_drops != 16'hFFFF) begin
          m_drops++;
        end
      end
      if (done_now) draining = 1'b0;
      else if (acc && in_bits_last) draining = 1'b1;
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge coder_clk) begin
    if (check_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("stream_done", 32'(stream_done), 32'(exp_done()));
      for (int i = 0; i < LANES; i++) begin
        chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          chk($sformatf("out_byte[%0d]", i), 32'(out_bits_byte[8*i +: 8]), 32'(exp_q[i][0][7:0]));
          chk($sformatf("out_last[%0d]", i), 32'(out_bits_last[i]), 32'(exp_q[i][0][8]));
        end
      end
`ifdef DEMUX_STATS_EN
      chk("stat_bytes", stat_bytes, 32'(m_bytes));
      chk("stat_drops", 32'(stat_drops), 32'(m_drops));
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge coder_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] idx, input logic [7:0] b, input logic l);
    in_valid     = 1'b1;
    in_bits_idx  = idx;
    in_bits_byte = b;
    in_bits_last = l;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    check_en = 1'b1;
    tick();
    @(negedge coder_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", out_bits_byte[31:0], 32'd0);
    chk("rst_out_last", 32'(out_bits_last), 32'd0);
    chk("rst_done", 32'(stream_done), 32'd0);
    tick();
    coder_rst = 1'b0;
    @(negedge coder_clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // routing: byte 0x10+i to lane i appears one cycle after acceptance
    out_ready = '1;
    for (int i = 0; i < LANES; i++) begin
      tick();
      drive(8'(i), 8'h10 + 8'(i), 1'b0);
      tick();
      in_valid = 1'b0;
      @(negedge coder_clk);
      chk($sformatf("route_valid[%0d]", i), 32'(out_valid), 32'(1) << i);
      chk($sformatf("route_byte[%0d]", i), 32'(out_bits_byte[8*i +: 8]), 32'h10 + 32'(i));
      chk($sformatf("route_last[%0d]", i), 32'(out_bits_last), 32'd0);
    end

    // backpressure on lane 3
    tick();
    out_ready = 8'hF7;
    for (int k = 0; k <= DEPTH; k++) begin
      tick();
      drive(8'd3, 8'h30 + 8'(k), 1'b0);
      @(negedge coder_clk);
      chk($sformatf("bp_ready[%0d]", k), 32'(in_ready), 32'(k < DEPTH));
    end
    tick();
    out_ready[3] = 1'b1;
    @(negedge coder_clk);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_bits_byte[31:24]), 32'h30);
    tick();
    @(negedge coder_clk);
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (24) tick();

    // illegal idx
    drive(8'd9, 8'hAA, 1'b0);
    @(negedge coder_clk);
    chk("illegal_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge coder_clk);
    chk("illegal_no_valid", 32'(out_valid), 32'd0);
`ifdef DEMUX_STATS_EN
    chk("illegal_drops", 32'(stat_drops), 32'd1);
`endif

    // end of stream
    tick();
    out_ready = '0;
    drive(8'd2, 8'h01, 1'b0);
    tick();
    drive(8'd5, 8'h02, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge coder_clk);
    chk("eos_ready", 32'(in_ready), 32'd0);
    chk("eos_last5", 32'(out_bits_last[5]), 32'd1);
    chk("eos_byte5", 32'(out_bits_byte[47:40]), 32'h02);
    chk("eos_done_early", 32'(stream_done), 32'd0);
    tick();
    out_ready = 8'h24;
    @(negedge coder_clk);
    chk("eos_done_pre", 32'(stream_done), 32'd0);
    tick();
    @(negedge coder_clk);
    chk("eos_done_pulse", 32'(stream_done), 32'd1);
    chk("eos_ready_in_pulse", 32'(in_ready), 32'd0);
    tick();
    @(negedge coder_clk);
    chk("eos_done_clear", 32'(stream_done), 32'd0);
    chk("eos_ready_back", 32'(in_ready), 32'd1);

    // simultaneous write and pop on lane 0 holding one entry
    tick();
    out_ready = '0;
    drive(8'd0, 8'h50, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    drive(8'd0, 8'h51, 1'b0);
    out_ready[0] = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = '0;
    @(negedge coder_clk);
    chk("sim_valid", 32'(out_valid[0]), 32'd1);
    chk("sim_head", 32'(out_bits_byte[7:0]), 32'h51);
    tick();
    out_ready = '1;
    tick();
    @(negedge coder_clk);
    chk("sim_drained", 32'(out_valid[0]), 32'd0);

    // reset mid-stream with 5 entries buffered
    tick();
    out_ready = '0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(i), 8'h60 + 8'(i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    coder_rst = 1'b1;
    tick();
    coder_rst = 1'b0;
    @(negedge coder_clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    tick();
    drive(8'd6, 8'h77, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge coder_clk);
    chk("mid_rst_alone", 32'(out_valid), 32'h40);
    chk("mid_rst_byte", 32'(out_bits_byte[55:48]), 32'h77);

    // randomized traffic, upstream holds a beat until accepted
    rdy_seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c == 2000) begin
        coder_rst = 1'b1;
        in_valid  = 1'b0;
      end else begin
        coder_rst = 1'b0;
        if (!(in_valid && !rdy_seen)) begin
          in_valid     = ($urandom_range(0, 3) != 0);
          in_bits_idx  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(8, 255))
                                                       : 8'($urandom_range(0, 7));
          in_bits_byte = 8'($urandom);
          in_bits_last = ($urandom_range(0, 149) == 0);
        end
        out_ready = 8'($urandom | $urandom);
      end
      @(negedge coder_clk);
      rdy_seen = in_ready;
    end

    tick();
    in_valid  = 1'b0;
    out_ready = '1;
    repeat (40) tick();
    @(negedge coder_clk);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
